msi_axil_writer: RTL and testbench

MSI_AXIL_WRITER -- requirements
Module: msi_axil_writer

---
 rtl/msi_axil_writer.sv | 180 ++++++++++++++++++
 tb/tb_msi_axil_writer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msi_axil_writer.sv
// rtl/msi_axil_writer.sv - round-robin MSI request collector issuing single AXI4-Lite writes
// Requests are queued FIFO and drained one AXI transaction at a time.
module msi_axil_writer #(
  parameter int NR_CH          = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  localparam int CH_W          = (NR_CH > 1) ? $clog2(NR_CH) : 1
) (
  input  logic                                     i_clk,
  input  logic                                     ni_rst,
  input  logic [NR_CH-1:0]                         i_valid,
  output logic [NR_CH-1:0]                         o_ready,
  input  logic [NR_CH-1:0][AXI_ADDR_WIDTH-1:0]     i_addr,
  input  logic [NR_CH-1:0][31:0]                   i_data,
  output logic                                     o_awvalid,
  input  logic                                     i_awready,
  output logic [AXI_ADDR_WIDTH-1:0]                o_awaddr,
  output logic [2:0]                               o_awprot,
  output logic                                     o_wvalid,
  input  logic                                     i_wready,
  output logic [AXI_DATA_WIDTH-1:0]                o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]              o_wstrb,
  input  logic                                     i_bvalid,
  output logic                                     o_bready,
  input  logic [1:0]                               i_bresp,
  output logic                                     o_busy,
  output logic                                     o_err,
  output logic [CH_W-1:0]                          o_err_ch
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = AXI_DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [CH_W-1:0]           fifo_ch_q   [FIFO_DEPTH];
  logic [AXI_ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [31:0]               fifo_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic [1:0]       state_q, state_d;
  logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]             wstrb_q, wstrb_d;

  logic [NR_CH-1:0] grant;
  logic [CH_W-1:0]  grant_idx;
  logic             grant_found;
  int               arb_idx;
  logic             push, pop;
  logic             aw_fin, w_fin;

  logic [CH_W-1:0]           head_ch;
  logic [AXI_ADDR_WIDTH-1:0] head_addr;
  logic [31:0]               head_data;

  assign head_ch   = fifo_ch_q[rd_ptr_q];
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // Fullness is judged on the registered count, so a pop never frees a slot in the same cycle.
  always_comb begin
    grant       = '0;
    grant_idx   = last_q;
    grant_found = 1'b0;
    arb_idx     = 0;
    if (count_q < DEPTH_C) begin
      for (int k = 1; k <= NR_CH; k++) begin
        arb_idx = (int'(last_q) + k) % NR_CH;
        if (!grant_found && i_valid[arb_idx]) begin
          grant_found      = 1'b1;
          grant[arb_idx]   = 1'b1;
          grant_idx        = CH_W'(arb_idx);
        end
      end
    end
  end

  assign o_ready = grant;
  assign push    = grant_found;
  assign pop     = (state_q == S_RESP) && i_bvalid;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    last_d   = push ? grant_idx : last_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_ch_q[wr_ptr_q]   <= grant_idx;
      fifo_addr_q[wr_ptr_q] <= i_addr[grant_idx];
      fifo_data_q[wr_ptr_q] <= i_data[grant_idx];
    end
  end

  assign aw_fin = !awvalid_q || i_awready;
  assign w_fin  = !wvalid_q  || i_wready;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d   = S_SEND;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = head_addr;
          wdata_d   = {(AXI_DATA_WIDTH/32){head_data}};
          // On a 64-bit bus the 32-bit word lands in the lane selected by address bit 2.
          wstrb_d   = SW'(4'hF);
          if (AXI_DATA_WIDTH == 64 && head_addr[2]) wstrb_d = SW'(8'hF0);
        end
      end
      S_SEND: begin
        if (awvalid_q && i_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_wready)   wvalid_d  = 1'b0;
        if (aw_fin && w_fin)        state_d   = S_RESP;
      end
      S_RESP: begin
        if (i_bvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_q    <= CH_W'(NR_CH - 1);
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign o_awvalid = awvalid_q;
  assign o_awaddr  = awaddr_q;
  assign o_awprot  = 3'b000;
  assign o_wvalid  = wvalid_q;
  assign o_wdata   = wdata_q;
  assign o_wstrb   = wstrb_q;
  assign o_bready  = (state_q == S_RESP);
  assign o_busy    = (count_q != '0);
  assign o_err     = pop && (i_bresp != 2'b00);
  assign o_err_ch  = o_err ? head_ch : '0;

endmodule

// File: tb/tb_msi_axil_writer.sv
// tb/tb_msi_axil_writer.sv - self-checking bench for msi_axil_writer
// Transaction-level queue model plus directed literal checks and random traffic.
module tb_msi_axil_writer;

  localparam int NR_CH = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              ni_rst = 1'b0;
  logic [3:0]        i_valid = '0;
  logic [3:0]        o_ready;
  logic [3:0][63:0]  i_addr = '0;
  logic [3:0][31:0]  i_data = '0;
  logic              o_awvalid, i_awready = 1'b0;
  logic [63:0]       o_awaddr;
  logic [2:0]        o_awprot;
  logic              o_wvalid, i_wready = 1'b0;
  logic [63:0]       o_wdata;
  logic [7:0]        o_wstrb;
  logic              i_bvalid = 1'b0, o_bready;
  logic [1:0]        i_bresp = 2'b00;
  logic              o_busy, o_err;
  logic [1:0]        o_err_ch;

  msi_axil_writer #(.NR_CH(4), .FIFO_DEPTH(4), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) dut (
    .i_clk(clk), .ni_rst(ni_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_data(i_data),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awprot(o_awprot),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_busy(o_busy), .o_err(o_err), .o_err_ch(o_err_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [63:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_last;
  bit   aw_seen, w_seen;

  int checks = 0, errors = 0, cyc = 0;
  int aw_cnt = 0, err_cnt = 0, bready_cnt = 0, aw_stall = 0;
  int last_err_ch, aw_hs_cyc, w_hs_cyc;
  logic [63:0] last_awaddr, last_wdata;
  logic [7:0]  last_wstrb;
  bit   st_acc, st_bhs;
  int   st_acc_ch;
  int   acc_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_grant(logic [3:0] v, int last, int cnt);
    if (cnt >= DEPTH) return 4'b0;
    for (int k = 1; k <= NR_CH; k++) begin
      int c;
      c = (last + k) % NR_CH;
      if (v[c]) return 4'(1 << c);
    end
    return 4'b0;
  endfunction

  function automatic logic [7:0] exp_strb(logic [63:0] a);
    return a[2] ? 8'hF0 : 8'h0F;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last  = NR_CH - 1;
    aw_seen = 0;
    w_seen  = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [3:0] eg;
    bit aw_hs, w_hs, b_hs, exp_err;
    ent_t e;
    @(negedge clk);
    eg = exp_grant(i_valid, m_last, mq.size());
    chk("o_ready", o_ready, eg);
    chk("o_busy", o_busy, mq.size() != 0);
    chk("o_bready", o_bready, aw_seen && w_seen);
    if (o_awvalid) begin
      chk("awvalid_legal", (mq.size() != 0) && !aw_seen, 1);
      if (mq.size() != 0) chk("o_awaddr", o_awaddr, mq[0].addr);
    end
    if (o_wvalid) begin
      chk("wvalid_legal", (mq.size() != 0) && !w_seen, 1);
      if (mq.size() != 0) begin
        chk("o_wdata", o_wdata, {mq[0].data, mq[0].data});
        chk("o_wstrb", o_wstrb, exp_strb(mq[0].addr));
      end
    end
    b_hs    = aw_seen && w_seen && i_bvalid && (mq.size() != 0);
    exp_err = b_hs && (i_bresp != 2'b00);
    chk("o_err", o_err, exp_err);
    if (exp_err) chk("o_err_ch", o_err_ch, mq[0].ch);
    if (o_err) begin err_cnt++; last_err_ch = int'(o_err_ch); end
    if (o_bready) bready_cnt++;
    aw_hs = o_awvalid && i_awready;
    w_hs  = o_wvalid && i_wready;
    if (o_awvalid && !i_awready) aw_stall++;
    if (aw_hs) begin aw_cnt++; last_awaddr = o_awaddr; aw_hs_cyc = cyc; end
    if (w_hs) begin last_wdata = o_wdata; last_wstrb = o_wstrb; w_hs_cyc = cyc; end
    st_acc = 0; st_bhs = b_hs; st_acc_ch = -1;
    for (int c = 0; c < NR_CH; c++) if (eg[c]) begin
      st_acc = 1; st_acc_ch = c;
      e.ch = c; e.addr = i_addr[c]; e.data = i_data[c];
    end
    @(posedge clk);
    if (b_hs) begin void'(mq.pop_front()); aw_seen = 0; w_seen = 0; end
    if (aw_hs) aw_seen = 1;
    if (w_hs)  w_seen = 1;
    if (st_acc) begin mq.push_back(e); m_last = st_acc_ch; acc_log.push_back(st_acc_ch); end
    cyc++;
    #1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    i_valid = '0; i_awready = 1; i_wready = 1; i_bvalid = 1; i_bresp = 2'b00;
    while (mq.size() != 0 && n < bound) begin step(); n++; end
    if (n >= bound) chk("drain_timeout", 1, 0);
    step();
  endtask

  task automatic push_one(input int c, input logic [63:0] a, input logic [31:0] d);
    int n = 0;
    i_addr[c] = a; i_data[c] = d; i_valid = 4'(1 << c);
    st_acc = 0;
    while (!st_acc && n < 20) begin step(); n++; end
    if (!st_acc) chk("accept_timeout", 0, 1);
    i_valid = '0;
  endtask

  task automatic do_reset();
    ni_rst = 0;
    i_valid = '0; i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
    repeat (2) @(posedge clk);
    #1 ni_rst = 1;
    model_reset();
  endtask

  initial begin
    int n, a0, e0;
    model_reset();
    #1;
    chk("rst_awvalid", o_awvalid, 0);
    chk("rst_wvalid", o_wvalid, 0);
    chk("rst_bready", o_bready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_err_ch", o_err_ch, 0);
    chk("rst_awaddr", o_awaddr, 0);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_wstrb", o_wstrb, 0);
    do_reset();

    // Single write, all slave channels ready.
    i_awready = 1; i_wready = 1; i_bvalid = 1;
    bready_cnt = 0;
    push_one(1, 64'h2400_1004, 32'h5);
    drain(20);
    chk("single_awaddr", last_awaddr, 64'h2400_1004);
    chk("single_wdata", last_wdata, 64'h0000_0005_0000_0005);
    chk("single_wstrb", last_wstrb, 8'hF0);
    chk("single_bready_cycles", bready_cnt, 1);
    chk("single_busy_after", o_busy, 0);

    // All channels requesting with a stalled slave: round-robin fill, then one pop frees one slot.
    do_reset();
    for (int c = 0; c < NR_CH; c++) begin
      i_addr[c] = 64'h1000_0000 + 64'(c * 4);
      i_data[c] = 32'hA0 + 32'(c);
    end
    acc_log.delete();
    i_valid = 4'hF;
    repeat (8) step();
    chk("fill_count", acc_log.size(), 4);
    for (int k = 0; k < 4 && k < acc_log.size(); k++) chk("fill_order", acc_log[k], k);
    chk("full_ready", o_ready, 0);
    i_awready = 1; i_wready = 1; i_bvalid = 1;
    n = 0; st_bhs = 0;
    while (!st_bhs && n < 20) begin step(); n++; end
    chk("full_bhs_seen", st_bhs, 1);
    chk("no_accept_on_pop_cycle", st_acc, 0);
    step();
    chk("accept_after_pop", st_acc, 1);
    chk("accept_after_pop_ch", st_acc_ch, 0);
    drain(100);

    // AW held off while W completes first.
    push_one(0, 64'h3000_0008, 32'h77);
    i_awready = 0; i_wready = 1; i_bvalid = 1;
    aw_stall = 0; aw_hs_cyc = -1; w_hs_cyc = -1;
    repeat (7) step();
    i_awready = 1;
    drain(20);
    chk("w_before_aw", (w_hs_cyc >= 0) && (w_hs_cyc < aw_hs_cyc), 1);
    chk("aw_stall_cycles", aw_stall >= 5, 1);
    chk("stall_wstrb", last_wstrb, 8'h0F);

    // Error response on a channel-2 write; the following entry still goes out.
    i_awready = 0; i_wready = 0; i_bvalid = 0;
    push_one(2, 64'h4000_0004, 32'h22);
    push_one(3, 64'h4000_0010, 32'h33);
    a0 = aw_cnt; e0 = err_cnt;
    i_awready = 1; i_wready = 1; i_bvalid = 1;
    n = 0;
    while (mq.size() != 0 && n < 40) begin
      i_bresp = (mq[0].ch == 2) ? 2'b10 : 2'b00;
      step(); n++;
    end
    i_bresp = 2'b00;
    chk("err_pulses", err_cnt - e0, 1);
    chk("err_channel", last_err_ch, 2);
    chk("err_next_issued", aw_cnt - a0, 2);

    // Reset while a write is in SEND with three entries queued.
    i_awready = 0; i_wready = 0; i_bvalid = 0;
    push_one(0, 64'h5000_0000, 32'h1);
    push_one(1, 64'h5000_0004, 32'h2);
    push_one(2, 64'h5000_0008, 32'h3);
    n = 0;
    while (!o_awvalid && n < 10) begin step(); n++; end
    chk("pre_reset_awvalid", o_awvalid, 1);
    #2 ni_rst = 0;
    #1;
    chk("midrst_awvalid", o_awvalid, 0);
    chk("midrst_wvalid", o_wvalid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_awaddr", o_awaddr, 0);
    chk("midrst_wdata", o_wdata, 0);
    @(posedge clk);
    #1 ni_rst = 1;
    model_reset();
    i_awready = 1; i_wready = 1; i_bvalid = 1;
    a0 = aw_cnt;
    repeat (6) step();
    chk("post_reset_no_aw", aw_cnt - a0, 0);
    chk("post_reset_busy", o_busy, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      i_valid = 4'($urandom_range(0, 15));
      for (int c = 0; c < NR_CH; c++) begin
        i_addr[c] = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
        i_data[c] = $urandom;
      end
      i_awready = ($urandom_range(0, 3) != 0);
      i_wready  = ($urandom_range(0, 3) != 0);
      i_bvalid  = ($urandom_range(0, 2) != 0);
      i_bresp   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step();
    end
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
